// File: rtl/ace_mem_responder_if.sv
// Shared ACE widths and the ACE bus interface seen by the memory responder.
// The snoop channels are present so the responder can tie them off.
package offnariscv_pkg;
  localparam int ACE_XDATA_WIDTH  = 256;
  localparam int ACE_AXADDR_WIDTH = 32;
  localparam int ACE_XID_WIDTH    = 4;
  localparam int ACE_XLEN_WIDTH   = 8;
  localparam int ACE_XUSER_WIDTH  = 1;
  localparam int ACE_RRESP_WIDTH  = 4;
  localparam int ACE_BRESP_WIDTH  = 2;
  localparam int ACE_SNOOP_WIDTH  = 4;
endpackage

interface ace_if;
  logic                                          arvalid;
  logic                                          arready;
  logic [offnariscv_pkg::ACE_XID_WIDTH-1:0]      arid;
  logic [offnariscv_pkg::ACE_AXADDR_WIDTH-1:0]   araddr;
  logic [offnariscv_pkg::ACE_XLEN_WIDTH-1:0]     arlen;

  logic                                          awvalid;
  logic                                          awready;
  logic [offnariscv_pkg::ACE_XID_WIDTH-1:0]      awid;
  logic [offnariscv_pkg::ACE_AXADDR_WIDTH-1:0]   awaddr;
  logic [offnariscv_pkg::ACE_XLEN_WIDTH-1:0]     awlen;

  logic                                          wvalid;
  logic                                          wready;
  logic [offnariscv_pkg::ACE_XDATA_WIDTH-1:0]    wdata;
  logic [offnariscv_pkg::ACE_XDATA_WIDTH/8-1:0]  wstrb;
  logic                                          wlast;

  logic                                          rvalid;
  logic                                          rready;
  logic [offnariscv_pkg::ACE_XDATA_WIDTH-1:0]    rdata;
  logic [offnariscv_pkg::ACE_RRESP_WIDTH-1:0]    rresp;
  logic [offnariscv_pkg::ACE_XID_WIDTH-1:0]      rid;
  logic                                          rlast;
  logic [offnariscv_pkg::ACE_XUSER_WIDTH-1:0]    ruser;

  logic                                          bvalid;
  logic                                          bready;
  logic [offnariscv_pkg::ACE_BRESP_WIDTH-1:0]    bresp;
  logic [offnariscv_pkg::ACE_XID_WIDTH-1:0]      bid;
  logic [offnariscv_pkg::ACE_XUSER_WIDTH-1:0]    buser;

  logic                                          rack;
  logic                                          wack;

  logic                                          acvalid;
  logic                                          acready;
  logic [offnariscv_pkg::ACE_AXADDR_WIDTH-1:0]   acaddr;
  logic [offnariscv_pkg::ACE_SNOOP_WIDTH-1:0]    acsnoop;
  logic                                          crvalid;
  logic                                          crready;
  logic                                          cdvalid;
  logic                                          cdready;

  modport responder (
    input  arvalid, arid, araddr, arlen,
    input  awvalid, awid, awaddr, awlen,
    input  wvalid, wdata, wstrb, wlast,
    input  rready, bready, rack, wack,
    input  acready, crvalid, cdvalid,
    output arready, awready, wready,
    output rvalid, rdata, rresp, rid, rlast, ruser,
    output bvalid, bresp, bid, buser,
    output acvalid, acaddr, acsnoop, crready, cdready
  );
endinterface

// File: rtl/ace_mem_responder.sv
// Single-outstanding ACE memory responder: one-line reads/writes into a
// line-wide backing store, with round-robin AR/AW arbitration and RACK/WACK.
module ace_mem_responder #(
  parameter int ACE_XDATA_WIDTH  = 256,
  parameter int ACE_AXADDR_WIDTH = 32,
  parameter int MEM_DEPTH        = 64
) (
  input logic        clk,
  input logic        rst,
  ace_if.responder   ace_if
);
  localparam int OFF_W = 5;
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int BYTES = ACE_XDATA_WIDTH / 8;
  localparam int ID_W  = offnariscv_pkg::ACE_XID_WIDTH;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE, RDATA, WAIT_RACK, WDATA, BRESP, WAIT_WACK
  } state_e;

  state_e                     r_state;
  state_e                     w_next;
  logic                       r_favour_ar;
  logic [ID_W-1:0]            r_id;
  logic [IDX_W-1:0]           r_idx;
  logic                       r_len_bad;
  logic                       r_oor;
  logic [1:0]                 r_resp;
  logic [ACE_XDATA_WIDTH-1:0] r_rdata;
  logic [ACE_XDATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic             w_ar_take;
  logic             w_aw_take;
  logic             w_w_fire;
  logic             w_wr_en;
  logic             w_ar_oor;
  logic             w_aw_oor;
  logic [IDX_W-1:0] w_ar_idx;
  logic [IDX_W-1:0] w_aw_idx;
  logic [1:0]       w_ar_resp;
  logic [1:0]       w_w_resp;
  logic             w_unused;

  assign w_ar_idx = ace_if.araddr[OFF_W +: IDX_W];
  assign w_aw_idx = ace_if.awaddr[OFF_W +: IDX_W];
  assign w_ar_oor = |ace_if.araddr[ACE_AXADDR_WIDTH-1:OFF_W+IDX_W];
  assign w_aw_oor = |ace_if.awaddr[ACE_AXADDR_WIDTH-1:OFF_W+IDX_W];

  // When both channels request, the pointer picks; otherwise the lone requester wins.
  assign w_ar_take = (r_state == IDLE) && ace_if.arvalid && (!ace_if.awvalid || r_favour_ar);
  assign w_aw_take = (r_state == IDLE) && ace_if.awvalid && (!ace_if.arvalid || !r_favour_ar);
  assign w_w_fire  = (r_state == WDATA) && ace_if.wvalid;

  assign w_ar_resp = w_ar_oor                  ? RESP_DECERR :
                     (ace_if.arlen != '0)      ? RESP_SLVERR : RESP_OKAY;
  assign w_w_resp  = r_oor                     ? RESP_DECERR :
                     (r_len_bad || !ace_if.wlast) ? RESP_SLVERR : RESP_OKAY;

  assign w_wr_en  = w_w_fire && (w_w_resp == RESP_OKAY) && !rst;
  assign w_unused = ^{ace_if.araddr[OFF_W-1:0], ace_if.awaddr[OFF_W-1:0],
                      ace_if.acready, ace_if.crvalid, ace_if.cdvalid};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_favour_ar <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_ar_take) r_favour_ar <= 1'b0;
      if (w_aw_take) r_favour_ar <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ar_take) begin
      r_id   <= ace_if.arid;
      r_resp <= w_ar_resp;
    end
    if (w_aw_take) begin
      r_id      <= ace_if.awid;
      r_idx     <= w_aw_idx;
      r_len_bad <= (ace_if.awlen != '0);
      r_oor     <= w_aw_oor;
    end
    if (w_w_fire) r_resp <= w_w_resp;
  end

  // NOTE: the backing store and its read register carry no reset; a cleared
  // array would cost a reset fan-out to every bit and contents are never
  // read before being written.
  always_ff @(posedge clk) begin
    if (w_ar_take) r_rdata <= (w_ar_resp == RESP_OKAY) ? r_mem[w_ar_idx] : '0;
    if (w_wr_en) begin
      for (int i = 0; i < BYTES; i++) begin
        if (ace_if.wstrb[i]) r_mem[r_idx][8*i +: 8] <= ace_if.wdata[8*i +: 8];
      end
    end
  end

  // NOTE: every signal driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next         = r_state;
    ace_if.arready = w_ar_take;
    ace_if.awready = w_aw_take;
    ace_if.wready  = 1'b0;
    ace_if.rvalid  = 1'b0;
    ace_if.rlast   = 1'b0;
    ace_if.bvalid  = 1'b0;
    ace_if.rdata   = r_rdata;
    ace_if.rresp   = {{(offnariscv_pkg::ACE_RRESP_WIDTH-2){1'b0}}, r_resp};
    ace_if.rid     = r_id;
    ace_if.ruser   = '0;
    ace_if.bresp   = r_resp;
    ace_if.bid     = r_id;
    ace_if.buser   = '0;
    ace_if.acvalid = 1'b0;
    ace_if.acaddr  = '0;
    ace_if.acsnoop = '0;
    ace_if.crready = 1'b1;
    ace_if.cdready = 1'b1;
    unique case (r_state)
      IDLE: begin
        if (w_ar_take)      w_next = RDATA;
        else if (w_aw_take) w_next = WDATA;
      end
      RDATA: begin
        ace_if.rvalid = 1'b1;
        ace_if.rlast  = 1'b1;
        if (ace_if.rready) w_next = WAIT_RACK;
      end
      WAIT_RACK: if (ace_if.rack) w_next = IDLE;
      WDATA: begin
        ace_if.wready = 1'b1;
        if (ace_if.wvalid) w_next = BRESP;
      end
      BRESP: begin
        ace_if.bvalid = 1'b1;
        if (ace_if.bready) w_next = WAIT_WACK;
      end
      WAIT_WACK: if (ace_if.wack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ace_mem_responder.sv
// Randomised self-checking bench for ace_mem_responder against a line-array
// reference model built from the addressing, response and strobe rules.
module tb_ace_mem_responder;
  localparam int DW    = 256;
  localparam int DEPTH = 64;
  localparam int NB    = DW / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ace_if u_if();

  ace_mem_responder #(
    .ACE_XDATA_WIDTH (DW),
    .ACE_AXADDR_WIDTH(32),
    .MEM_DEPTH       (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ace_if(u_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mdl_mem [DEPTH];
  bit            mdl_written [DEPTH];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit mdl_oor(input logic [31:0] addr);
    return (addr / 32) >= DEPTH;
  endfunction

  function automatic int mdl_idx(input logic [31:0] addr);
    return int'((addr / 32) % DEPTH);
  endfunction

  function automatic logic [1:0] mdl_resp(input logic [31:0] addr, input logic [7:0] len, input bit last);
    if (mdl_oor(addr)) return 2'b11;
    if (len != 0 || !last) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_inputs();
    u_if.arvalid = 0; u_if.arid = '0; u_if.araddr = '0; u_if.arlen = '0;
    u_if.awvalid = 0; u_if.awid = '0; u_if.awaddr = '0; u_if.awlen = '0;
    u_if.wvalid  = 0; u_if.wdata = '0; u_if.wstrb = '0; u_if.wlast = 0;
    u_if.rready  = 0; u_if.bready = 0; u_if.rack = 0; u_if.wack = 0;
    u_if.acready = 0; u_if.crvalid = 0; u_if.cdvalid = 0;
  endtask

  // Entered just after a falling edge with a valid raised; leaves the bench
  // at the sample point before the rising edge that completes the handshake.
  task automatic wait_hs(input string tag, input bit is_ar);
    int   n;
    logic rdy;
    n = 0;
    #1;
    rdy = is_ar ? u_if.arready : u_if.awready;
    while (!rdy && n < 20) begin
      @(negedge clk); #1;
      rdy = is_ar ? u_if.arready : u_if.awready;
      n++;
    end
    check({tag, "_ready"}, rdy, 1);
  endtask

  task automatic ar_phase(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    u_if.arvalid = 1; u_if.araddr = addr; u_if.arid = id; u_if.arlen = len;
    wait_hs("ar", 1);
    @(negedge clk);
    u_if.arvalid = 0;
  endtask

  task automatic read_rest(input logic [DW-1:0] exp_data, input logic [1:0] exp_resp,
                           input logic [3:0] id, input int stall, input bit chk_aw);
    #1;
    check("rvalid", u_if.rvalid, 1);
    check("rdata", u_if.rdata, exp_data);
    check("rresp", u_if.rresp, {2'b00, exp_resp});
    check("rid", u_if.rid, id);
    check("rlast", u_if.rlast, 1);
    check("ruser", u_if.ruser, 0);
    if (chk_aw) check("aw_blocked_rdata", u_if.awready, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk); #1;
      check("rvalid_hold", u_if.rvalid, 1);
      check("rdata_hold", u_if.rdata, exp_data);
      check("rid_hold", u_if.rid, id);
      if (chk_aw) check("aw_blocked_stall", u_if.awready, 0);
    end
    u_if.rready = 1;
    @(negedge clk);
    u_if.rready = 0; u_if.wack = 1; u_if.arvalid = 1;
    #1;
    check("rvalid_after_hs", u_if.rvalid, 0);
    check("ar_blocked_rack", u_if.arready, 0);
    if (chk_aw) check("aw_blocked_rack", u_if.awready, 0);
    @(negedge clk);
    u_if.wack = 0; u_if.rack = 1;
    #1;
    check("stray_wack_ignored", u_if.arready, 0);
    @(negedge clk);
    u_if.rack = 0; u_if.arvalid = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input int stall);
    logic [1:0]    resp;
    logic [DW-1:0] exp;
    resp = mdl_resp(addr, len, 1'b1);
    exp  = (resp == 2'b00) ? mdl_mem[mdl_idx(addr)] : '0;
    ar_phase(addr, id, len);
    read_rest(exp, resp, id, stall, 1'b0);
  endtask

  task automatic aw_phase(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    u_if.awvalid = 1; u_if.awaddr = addr; u_if.awid = id; u_if.awlen = len;
    wait_hs("aw", 0);
    @(negedge clk);
    u_if.awvalid = 0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [DW-1:0] data, input logic [NB-1:0] strb,
                          input bit last, input int stall);
    logic [1:0] resp;
    int         idx;
    resp = mdl_resp(addr, len, last);
    idx  = mdl_idx(addr);
    aw_phase(addr, id, len);
    u_if.wvalid = 1; u_if.wdata = data; u_if.wstrb = strb; u_if.wlast = last;
    #1;
    check("wready", u_if.wready, 1);
    @(negedge clk);
    u_if.wvalid = 0;
    if (resp == 2'b00) begin
      for (int b = 0; b < NB; b++)
        if (strb[b]) mdl_mem[idx][8*b +: 8] = data[8*b +: 8];
      mdl_written[idx] = 1;
    end
    #1;
    check("bvalid", u_if.bvalid, 1);
    check("bresp", u_if.bresp, resp);
    check("bid", u_if.bid, id);
    check("buser", u_if.buser, 0);
    check("wready_after_hs", u_if.wready, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk); #1;
      check("bvalid_hold", u_if.bvalid, 1);
      check("bresp_hold", u_if.bresp, resp);
    end
    u_if.bready = 1;
    @(negedge clk);
    u_if.bready = 0; u_if.rack = 1; u_if.awvalid = 1;
    #1;
    check("bvalid_after_hs", u_if.bvalid, 0);
    check("aw_blocked_wack", u_if.awready, 0);
    @(negedge clk);
    u_if.rack = 0; u_if.wack = 1;
    #1;
    check("stray_rack_ignored", u_if.awready, 0);
    @(negedge clk);
    u_if.wack = 0; u_if.awvalid = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    logic [31:0]   addr;
    logic [NB-1:0] strb;
    logic [7:0]    len;
    bit            last;
    int            idx;

    idle_inputs();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    check("rst_arready", u_if.arready, 0);
    check("rst_awready", u_if.awready, 0);
    check("rst_wready", u_if.wready, 0);
    check("rst_rvalid", u_if.rvalid, 0);
    check("rst_bvalid", u_if.bvalid, 0);
    check("rst_acvalid", u_if.acvalid, 0);
    check("crready", u_if.crready, 1);
    check("cdready", u_if.cdready, 1);

    // Simultaneous AR (arlen=1) and AW right after reset: AR first, AW after rack.
    d = rand_line();
    u_if.awvalid = 1; u_if.awaddr = 32'h40; u_if.awid = 4'h5; u_if.awlen = 0;
    u_if.arvalid = 1; u_if.araddr = 32'h40; u_if.arid = 4'h3; u_if.arlen = 8'd1;
    #1;
    check("rr_first_ar", u_if.arready, 1);
    check("rr_first_aw_wait", u_if.awready, 0);
    ar_phase(32'h40, 4'h3, 8'd1);
    read_rest('0, 2'b10, 4'h3, 2, 1'b1);
    #1;
    check("aw_after_rack", u_if.awready, 1);
    do_write(32'h40, 4'h5, 0, d, '1, 1'b1, 2);

    do_read(32'h40, 4'h7, 0, 5);
    do_write(32'h40, 4'h1, 0, rand_line(), 32'h0000_000F, 1'b1, 0);
    do_read(32'h40, 4'h2, 0, 0);

    do_write(32'h00, 4'h4, 0, rand_line(), '1, 1'b1, 1);
    do_write(32'h8000_0000, 4'h2, 0, rand_line(), '1, 1'b1, 1);
    do_read(32'h00, 4'h6, 0, 0);
    do_write(32'h40, 4'h8, 0, rand_line(), '1, 1'b0, 0);
    do_write(32'h40, 4'h9, 8'd1, rand_line(), '1, 1'b1, 0);
    do_read(32'h40, 4'hA, 0, 1);
    do_read(32'h8000_0040, 4'hB, 0, 0);

    for (int t = 0; t < 60; t++) begin
      idx = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 0) begin
        addr = (idx * 32) | $urandom_range(0, 31);
        if ($urandom_range(0, 9) == 0) addr = addr | (32'h1 << $urandom_range(11, 31));
        len  = ($urandom_range(0, 9) == 0) ? 8'd1 : 8'd0;
        last = ($urandom_range(0, 9) != 0);
        strb = ($urandom_range(0, 1) == 0) ? '1 : NB'($urandom);
        if (!mdl_written[mdl_idx(addr)]) strb = '1;
        do_write(addr, 4'($urandom), len, rand_line(), strb, last, $urandom_range(0, 3));
      end else begin
        if (!mdl_written[idx]) idx = 2;
        addr = (idx * 32) | $urandom_range(0, 31);
        len  = ($urandom_range(0, 9) == 0) ? 8'd1 : 8'd0;
        if ($urandom_range(0, 9) == 0) addr = addr | (32'h1 << $urandom_range(11, 31));
        do_read(addr, 4'($urandom), len, $urandom_range(0, 3));
      end
    end

    // Reset while in WDATA: no B response, no write, arbitration favours AR again.
    aw_phase(32'h40, 4'hC, 0);
    u_if.wvalid = 1; u_if.wdata = rand_line(); u_if.wstrb = '1; u_if.wlast = 1;
    rst = 1;
    #1;
    check("wready_before_rst", u_if.wready, 1);
    @(negedge clk);
    rst = 0; u_if.wvalid = 0;
    #1;
    check("rst_mid_wready", u_if.wready, 0);
    check("rst_mid_bvalid", u_if.bvalid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("rst_mid_no_bvalid", u_if.bvalid, 0);
    end
    u_if.awvalid = 1; u_if.awaddr = 32'h60; u_if.awid = 4'hD; u_if.awlen = 0;
    u_if.arvalid = 1; u_if.araddr = 32'h40; u_if.arid = 4'hE; u_if.arlen = 0;
    #1;
    check("rr_after_rst_ar", u_if.arready, 1);
    check("rr_after_rst_aw_wait", u_if.awready, 0);
    ar_phase(32'h40, 4'hE, 0);
    read_rest(mdl_mem[2], 2'b00, 4'hE, 0, 1'b1);
    do_write(32'h60, 4'hD, 0, rand_line(), '1, 1'b1, 0);
    do_read(32'h60, 4'hF, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
